seq_comparator_param: RTL
=========================

Name: seq_comparator_param

Overview:
- Parametrised, multi-cycle successor to the 8-bit cascaded equal/greater comparator.
- Compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, and supports a signed mode.
- Terminates early once the result is decided, and reports EQ/GT/LT through a start/busy/done handshake.
- Serves as the area-lean comparator for datapaths where one compare per several cycles is sufficient.

Parameters:
- WIDTH, 8, operand width in bits; must be ≥ 2.
- DIGIT, 1, bits compared per cycle; must divide WIDTH. N = WIDTH/DIGIT chunks.
- EARLY_EXIT, 1, 1 = finish on the first differing chunk; 0 = always run all N chunks.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a compare; sampled on the rising edge.
- in1  input  WIDTH  operand A; captured when start is accepted.
- in2  input  WIDTH  operand B; captured when start is accepted.
- signed_mode  input  1  1 = two's-complement compare; captured with the operands.
- busy  output  1  high while a compare is in progress (RUN state).
- done  output  1  one-cycle pulse; EQ/GT/LT are valid in this cycle.
- EQ  output  1  in1 == in2.
- GT  output  1  in1 > in2.
- LT  output  1  in1 < in2.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; busy = done = EQ = GT = LT = 0; internal registers cleared. Reset during RUN aborts the compare, and no done pulse is produced.
- States: IDLE, RUN, DONE.
  - IDLE: start = 1 at an edge → capture operands and mode; set cnt = 0, eq_acc = 1, gt_acc = 0; go to RUN.
  - RUN: at each edge, evaluate chunk k = N-1-cnt, i.e. bits [k*DIGIT+DIGIT-1 : k*DIGIT].
    - If eq_acc and A_chunk != B_chunk: eq_acc ← 0, gt_acc ← (A_chunk > B_chunk, unsigned).
    - Chunks after the first difference never change eq_acc or gt_acc.
    - Go to DONE when cnt == N-1, or when EARLY_EXIT = 1 and a difference was found at this edge. Otherwise cnt ← cnt + 1.
  - DONE: done = 1 for exactly one cycle. EQ = eq_acc, GT = gt_acc, LT = ~eq_acc & ~gt_acc are registered on entry to DONE.
    - start = 1 at this edge → new capture, go to RUN (back-to-back compares allowed).
    - Otherwise go to IDLE.
- Signed mode: the MSB of both operands is inverted at capture (offset-binary), so the unsigned chunk compare yields the signed order. The inversion is applied only when signed_mode = 1.
- Exactly one of EQ/GT/LT is 1 from the first done onward; all are 0 only after reset. EQ/GT/LT hold their values through IDLE until the next DONE entry.
- Latency: with the start edge as E0, done is high in the cycle after edge E(j+1).
  - j = index (MSB-first, from 0) of the first differing chunk when EARLY_EXIT = 1.
  - Otherwise j = N-1.
  - Full compare: done rises N cycles after the start edge.
- start while busy (RUN) is ignored; operand changes during RUN have no effect.
- busy = 1 exactly in RUN; busy and done are never high together.
- N = 1 (DIGIT = WIDTH): RUN lasts one edge; done follows one cycle after start.
- cnt width is clog2(N), minimum 1; cnt never wraps within a compare.

Test Plan:
- WIDTH=8, DIGIT=1, unsigned, in1=in2=0xA5 → EQ=1, GT=LT=0; busy for 8 cycles; done pulses once, 8 cycles after the start edge.
- WIDTH=8, DIGIT=1, EARLY_EXIT=1, unsigned 0x80 vs 0x7F → GT=1, done 1 cycle after start. Same operands with signed_mode=1 → LT=1, done 1 cycle after start.
- WIDTH=16, DIGIT=4: 0x1234 vs 0x1235 → LT=1, done after 4 cycles. 0x1234 vs 0x0234 with EARLY_EXIT=0 → GT=1, done after 4 cycles (no early stop).
- start re-asserted with new operands during RUN → ignored; the result matches the first operands. start high in the done cycle → second compare starts immediately, with a second done pulse and the correct result.
- rst_n pulsed low mid-RUN (asynchronous, between edges) → outputs 0 immediately, no done pulse. A subsequent start compares correctly.
- Randomised signed/unsigned 8- and 16-bit operands (DIGIT 1, 2, 4, 8) vs a reference model → exactly one of EQ/GT/LT set, matching the model; latency matches the early-exit formula.

Source files
------------

// File: rtl/seq_comparator_param.sv
// seq_comparator_param: multi-cycle MSB-first magnitude comparator.
// Operands are compared DIGIT bits per clock. The first differing chunk
// decides the result. Signed mode flips the operand MSBs when they are
// captured, which turns two's complement into offset binary so that one
// unsigned chunk compare covers both modes.
module seq_comparator_param #(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 1,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             EQ,
  output logic             GT,
  output logic             LT
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST     = CW'(N - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             eq_acc_q, eq_acc_d;
  logic             gt_acc_q, gt_acc_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;

  logic [N-1:0][DIGIT-1:0] a_chunks;
  logic [N-1:0][DIGIT-1:0] b_chunks;
  logic [CW-1:0]           chunk_idx;
  logic [DIGIT-1:0]        a_chunk;
  logic [DIGIT-1:0]        b_chunk;
  logic                    diff_now;
  logic                    load;

  // Pick the chunk for this cycle. The count runs from the MSB chunk down.
  always_comb begin
    a_chunks  = a_q;
    b_chunks  = b_q;
    chunk_idx = LAST - cnt_q;
    a_chunk   = a_chunks[chunk_idx];
    b_chunk   = b_chunks[chunk_idx];
  end

  // Next-state logic: handshake FSM, compare accumulators, operand capture.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    eq_acc_d = eq_acc_q;
    gt_acc_d = gt_acc_q;
    eq_d     = eq_q;
    gt_d     = gt_q;
    lt_d     = lt_q;
    load     = 1'b0;
    diff_now = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // Once a difference is latched, eq_acc is low and later chunks
        // can no longer change the result.
        diff_now = eq_acc_q && (a_chunk != b_chunk);
        if (diff_now) begin
          eq_acc_d = 1'b0;
          gt_acc_d = (a_chunk > b_chunk);
        end
        if ((cnt_q == LAST) || ((EARLY_EXIT != 0) && diff_now)) begin
          state_d = DONE;
          eq_d    = eq_acc_d;
          gt_d    = gt_acc_d;
          lt_d    = ~eq_acc_d & ~gt_acc_d;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      a_d      = in1 ^ (signed_mode ? MSB_MASK : '0);
      b_d      = in2 ^ (signed_mode ? MSB_MASK : '0);
      cnt_d    = '0;
      eq_acc_d = 1'b1;
      gt_acc_d = 1'b0;
    end
  end

  // State and datapath registers. An asynchronous reset aborts any compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      eq_acc_q <= 1'b0;
      gt_acc_q <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      eq_acc_q <= eq_acc_d;
      gt_acc_q <= gt_acc_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign EQ   = eq_q;
  assign GT   = gt_q;
  assign LT   = lt_q;

endmodule
